game_round_controller: RTL and testbench
========================================

# game_round_controller

Sequences one whack-a-mole game round around the existing spawn/score datapath. Runs a start countdown, then a fixed-length play period, then a game-over hold. It gates mole spawning, issues the score-restart pulse, and auto-advances the difficulty level from score thresholds. It sits between the debounced/edge-detected buttons and the score_counter, difficulty, rng_mole and mole-control logic.

## Interface
- TICK_CYCLES, 50_000_000: clk cycles per one-second tick (set small in simulation)
- COUNTDOWN_S, 3: pre-game countdown length in seconds (1–3)
- GAME_S, 60: play length in seconds (1–99)
- LEVEL_STEP, 20: score increase needed per level-up
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  single-cycle pulse (posedge-detected button)
- pause  in  1  single-cycle pulse (posedge-detected button)
- score  in  11  current score from score_counter
- score_restart  out  1  one-cycle pulse to score_counter restart
- spawn_enable  out  1  high only in PLAY; gates mole-control timer
- level  out  2  difficulty level 0–3
- countdown  out  2  seconds remaining in COUNTDOWN, else 0
- time_left  out  7  play seconds remaining
- game_over  out  1  high in OVER
- high_score  out  11  best final score since reset

## Operation
- States: IDLE, COUNTDOWN, PLAY, PAUSED, OVER. Encoding is in the package.
- IDLE, start → COUNTDOWN.
  - Pulse score_restart.
  - Load countdown=COUNTDOWN_S, time_left=GAME_S, level=0, threshold=LEVEL_STEP.
  - Clear prescaler.
- COUNTDOWN: each tick decrements countdown. A tick arriving when countdown==1 → PLAY, with countdown=0 and prescaler cleared.
- PLAY:
  - Each tick decrements time_left. A tick arriving when time_left==1 → OVER, with time_left=0.
  - pause → PAUSED.
  - start → restart sequence, same as from IDLE.
- PAUSED:
  - Prescaler frozen; all outputs held; spawn_enable=0.
  - pause → PLAY, resuming the prescaler from its frozen count.
  - start → restart sequence.
- OVER:
  - game_over=1.
  - On the entry cycle, high_score ← max(high_score, score).
  - start → restart sequence.
  - pause ignored.
- Level rule, evaluated in PLAY only:
  - If score ≥ threshold and level<3, then level+1 and threshold+LEVEL_STEP.
  - At most one step per cycle. Saturates at 3.
  - Threshold is 12 bits, so it cannot overflow.
- Priority: start beats pause in every state. Tick and pause in the same PLAY cycle: the tick is applied, then the block enters PAUSED.
- score is treated as already synchronous. The block never writes score except via score_restart.

## Timing
- All outputs are registered. Reset values:
  - state IDLE
  - score_restart 0, spawn_enable 0, level 0, countdown 0, time_left 0, game_over 0, high_score 0
  - prescaler 0, threshold LEVEL_STEP
- Reset mid-round aborts to IDLE immediately (asynchronously). high_score is also cleared.
- A start pulse in cycle N gives state/outputs updated at edge N+1. score_restart is high exactly for cycle N+1.
- Tick = prescaler reaching TICK_CYCLES-1. The prescaler wraps to 0 that same edge, and counts only in COUNTDOWN and PLAY.
- The first countdown decrement occurs TICK_CYCLES cycles after entry. Same for time_left after PLAY entry.
- spawn_enable rises the edge PLAY is entered and falls the edge PLAY is left.
- Level update latency: one cycle after score crosses threshold.
- high_score is compared on the OVER entry edge. It is visible the following cycle.

## Structure
- Package game_pkg holds:
  - state enum game_state_t
  - localparams SCORE_W=11, LEVEL_W=2, MAX_LEVEL=3
- Natural sub-module: second_ticker.
  - Prescaler with enable and clear; outputs one-cycle tick.
  - Reusable by other timed modules.
- Remainder is a single FSM plus the level/threshold and high-score registers.

## Test plan
All scenarios use TICK_CYCLES=10, COUNTDOWN_S=3, GAME_S=5, LEVEL_STEP=4.
- Reset, then start → score_restart high one cycle. countdown reads 3,2,1 at 10-cycle spacing. spawn_enable rises 30 cycles after start. time_left=5.
- Full round, score held 0 → time_left steps 5→0 over 50 cycles. game_over=1, spawn_enable=0, high_score=0.
- In PLAY, drive score 3→4→9→13 → level 0→1→2→3 one cycle after each crossing. Further score 20 leaves level=3.
- Pause at time_left=3 mid-second, hold 100 cycles, then pause → time_left still 3. The next decrement comes after the remaining prescaler count, not a full 10.
- Game ends with score 7 → high_score=7. Second game ends with score 5 → high_score stays 7. start in OVER pulses score_restart and resets level to 0.
- Assert reset during PLAY at level 2 → all outputs 0 and state IDLE with no clock edge. start and pause in the same cycle in PLAY → restart taken, no PAUSED.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the game round controller
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        PLAY,
        PAUSED,
        OVER
    } game_state_t;

    localparam int SCORE_W   = 11;
    localparam int LEVEL_W   = 2;
    localparam int MAX_LEVEL = 3;

endpackage

// File: rtl/second_ticker.sv
// rtl/second_ticker.sv - prescaler producing a one-cycle tick every TICK_CYCLES enabled cycles
module second_ticker #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Tick is independent of clear so a caller can clear on the very tick it consumes.
    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - sequences countdown, play, pause and game-over for one round
module game_round_controller
    import game_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int COUNTDOWN_S = 3,
    parameter int GAME_S      = 60,
    parameter int LEVEL_STEP  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic [SCORE_W-1:0] score,
    output logic               score_restart,
    output logic               spawn_enable,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         countdown,
    output logic [6:0]         time_left,
    output logic               game_over,
    output logic [SCORE_W-1:0] high_score
);

    game_state_t state;
    logic [11:0] threshold;
    logic        tick;
    logic        tick_enable;
    logic        tick_clear;
    logic        level_up;

    assign tick_enable = (state == COUNTDOWN) || (state == PLAY);
    assign tick_clear  = start || ((state == COUNTDOWN) && tick && (countdown == 2'd1));
    assign level_up    = ({1'b0, score} >= threshold) && (level != LEVEL_W'(MAX_LEVEL));

    second_ticker #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_ticker (
        .clk   (clk),
        .reset (reset),
        .enable(tick_enable),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            score_restart <= 1'b0;
            spawn_enable  <= 1'b0;
            level         <= '0;
            countdown     <= '0;
            time_left     <= '0;
            game_over     <= 1'b0;
            high_score    <= '0;
            threshold     <= 12'(LEVEL_STEP);
        end else begin
            score_restart <= 1'b0;
            // start outranks everything, including pause and ticks
            if (start) begin
                state         <= COUNTDOWN;
                score_restart <= 1'b1;
                spawn_enable  <= 1'b0;
                game_over     <= 1'b0;
                level         <= '0;
                threshold     <= 12'(LEVEL_STEP);
                countdown     <= 2'(COUNTDOWN_S);
                time_left     <= 7'(GAME_S);
            end else begin
                case (state)
                    IDLE: ;
                    COUNTDOWN: begin
                        if (tick) begin
                            if (countdown == 2'd1) begin
                                countdown    <= '0;
                                state        <= PLAY;
                                spawn_enable <= 1'b1;
                            end else begin
                                countdown <= countdown - 2'd1;
                            end
                        end
                    end
                    PLAY: begin
                        if (level_up) begin
                            level     <= level + 1'b1;
                            threshold <= threshold + 12'(LEVEL_STEP);
                        end
                        if (tick && (time_left == 7'd1)) begin
                            time_left    <= '0;
                            state        <= OVER;
                            spawn_enable <= 1'b0;
                            game_over    <= 1'b1;
                            high_score   <= (score > high_score) ? score : high_score;
                        end else begin
                            if (tick) begin
                                time_left <= time_left - 7'd1;
                            end
                            if (pause) begin
                                state        <= PAUSED;
                                spawn_enable <= 1'b0;
                            end
                        end
                    end
                    PAUSED: begin
                        if (pause) begin
                            state        <= PLAY;
                            spawn_enable <= 1'b1;
                        end
                    end
                    OVER: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// tb/tb_game_round_controller.sv - directed scoreboard bench for game_round_controller
module tb_game_round_controller;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [10:0] score;
    logic        score_restart;
    logic        spawn_enable;
    logic [1:0]  level;
    logic [1:0]  countdown;
    logic [6:0]  time_left;
    logic        game_over;
    logic [10:0] high_score;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;
    exp_t sb[$];

    game_round_controller #(
        .TICK_CYCLES(10),
        .COUNTDOWN_S(3),
        .GAME_S     (5),
        .LEVEL_STEP (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .score        (score),
        .score_restart(score_restart),
        .spawn_enable (spawn_enable),
        .level        (level),
        .countdown    (countdown),
        .time_left    (time_left),
        .game_over    (game_over),
        .high_score   (high_score)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.value)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.value);
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] v);
        sb_push(tag, v);
        sb_check(obs);
    endtask

    task automatic start_round();
        sb_push("restart_pulse", 1);
        sb_push("restart_level", 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        sb_check(32'(score_restart));
        sb_check(32'(level));
        step(29);
        sb_push("spawn_on_play", 1);
        step(1);
        sb_check(32'(spawn_enable));
    endtask

    task automatic wait_over();
        int n = 0;
        while (!game_over && n < 200) begin
            step(1);
            n++;
        end
        expect_now("game_over_reached", 32'(game_over), 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        score = '0;
        #2;
        expect_now("rst_restart",   32'(score_restart), 0);
        expect_now("rst_spawn",     32'(spawn_enable), 0);
        expect_now("rst_level",     32'(level), 0);
        expect_now("rst_countdown", 32'(countdown), 0);
        expect_now("rst_time_left", 32'(time_left), 0);
        expect_now("rst_game_over", 32'(game_over), 0);
        expect_now("rst_high",      32'(high_score), 0);
        expect_now("rst_state",     32'(dut.state), 32'(IDLE));
        step(2);
        reset = 1'b0;
        step(2);

        // countdown 3,2,1 at 10-cycle spacing, then PLAY 30 edges after start
        sb_push("cd_restart", 1);
        sb_push("cd_load", 3);
        sb_push("tl_load", 5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        sb_check(32'(score_restart));
        sb_check(32'(countdown));
        sb_check(32'(time_left));
        step(1);
        expect_now("restart_one_cycle", 32'(score_restart), 0);
        step(8);
        expect_now("cd_still3", 32'(countdown), 3);
        step(1);
        expect_now("cd_2", 32'(countdown), 2);
        step(10);
        expect_now("cd_1", 32'(countdown), 1);
        step(9);
        expect_now("spawn_before_play", 32'(spawn_enable), 0);
        step(1);
        expect_now("spawn_at_play", 32'(spawn_enable), 1);
        expect_now("cd_0", 32'(countdown), 0);
        expect_now("tl_5", 32'(time_left), 5);

        // full round with score 0
        for (int s = 4; s >= 1; s--) begin
            step(10);
            expect_now("tl_step", 32'(time_left), 32'(s));
        end
        step(9);
        expect_now("not_over_yet", 32'(game_over), 0);
        step(1);
        expect_now("over_flag", 32'(game_over), 1);
        expect_now("over_tl0", 32'(time_left), 0);
        expect_now("over_spawn", 32'(spawn_enable), 0);
        step(1);
        expect_now("high_zero", 32'(high_score), 0);

        // level stepping, then finish with score 7
        start_round();
        score = 11'd3;
        step(2);
        expect_now("lvl_0", 32'(level), 0);
        score = 11'd4;
        step(1);
        expect_now("lvl_1", 32'(level), 1);
        score = 11'd9;
        step(1);
        expect_now("lvl_2", 32'(level), 2);
        score = 11'd13;
        step(1);
        expect_now("lvl_3", 32'(level), 3);
        score = 11'd20;
        step(3);
        expect_now("lvl_sat", 32'(level), 3);
        score = 11'd7;
        wait_over();
        step(1);
        expect_now("high_7", 32'(high_score), 7);

        // restart from OVER, pause mid-second, finish with score 5
        score = 11'd0;
        start_round();
        score = 11'd5;
        step(20);
        expect_now("pre_pause_tl3", 32'(time_left), 3);
        step(5);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        expect_now("paused_spawn", 32'(spawn_enable), 0);
        expect_now("paused_state", 32'(dut.state), 32'(PAUSED));
        step(100);
        expect_now("paused_tl_hold", 32'(time_left), 3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        expect_now("resume_spawn", 32'(spawn_enable), 1);
        step(3);
        expect_now("resume_tl_hold", 32'(time_left), 3);
        step(1);
        expect_now("resume_tl_dec", 32'(time_left), 2);
        wait_over();
        step(1);
        expect_now("high_keep_7", 32'(high_score), 7);

        // asynchronous reset during PLAY at level 2
        score = 11'd0;
        start_round();
        score = 11'd9;
        step(3);
        expect_now("pre_rst_lvl2", 32'(level), 2);
        reset = 1'b1;
        #1;
        expect_now("arst_state", 32'(dut.state), 32'(IDLE));
        expect_now("arst_spawn", 32'(spawn_enable), 0);
        expect_now("arst_level", 32'(level), 0);
        expect_now("arst_tl",    32'(time_left), 0);
        expect_now("arst_high",  32'(high_score), 0);
        step(2);
        reset = 1'b0;
        score = 11'd0;
        step(1);

        // start and pause together in PLAY: restart wins
        start_round();
        start = 1'b1;
        pause = 1'b1;
        step(1);
        start = 1'b0;
        pause = 1'b0;
        expect_now("both_restart", 32'(score_restart), 1);
        expect_now("both_state", 32'(dut.state), 32'(COUNTDOWN));
        expect_now("both_cd", 32'(countdown), 3);
        expect_now("both_spawn", 32'(spawn_enable), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
